axi_wrr_arbiter: RTL and testbench
==================================

AXI_WRR_ARBITER -- requirements
Module: axi_wrr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter WEIGHT_W, default 4, width of each requester weight.
REQ-003 SHALL have port aclk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  N_REQ  per-requester request, bit i = requester i.
REQ-006 SHALL have port weight_i  input  N_REQ*WEIGHT_W  packed weights, requester i at bits [i*WEIGHT_W +: WEIGHT_W].
REQ-007 SHALL have port ack_i  input  1  current transaction complete; releases the grant.
REQ-008 SHALL have port grant_o  output  N_REQ  one-hot registered grant.
REQ-009 SHALL have port grant_idx_o  output  $clog2(N_REQ)  binary index of the granted requester; valid while busy_o=1.
REQ-010 SHALL have port busy_o  output  1  high when in state GRANT.

Function
REQ-011 SHALL implement two states: IDLE, GRANT.
REQ-012 SHALL hold registers ptr (last winner index), rem (remaining consecutive grants, WEIGHT_W bits) and grant_q.
REQ-013 SHALL define eff_w(i) = weight_i[i], or 1 when weight_i[i]=0.
REQ-014 IDLE with req_i=0: SHALL stay IDLE and keep grant_o=0.
REQ-015 IDLE with req_i!=0: SHALL select one winner w, load grant_q=onehot(w), set ptr=w and enter GRANT on the next edge; grant latency is 1 cycle from the request.
REQ-016 Favoured path: if req_i[ptr]=1 and rem!=0, w SHALL be ptr and rem SHALL decrement by 1.
REQ-017 Search path: otherwise w SHALL be the first requesting index in order ptr+1, ptr+2, ..., ptr+N_REQ (mod N_REQ), and rem SHALL load eff_w(w)-1.
REQ-018 weight_i SHALL be sampled only at the selection edge; changes during GRANT have no effect on the current grant.
REQ-019 GRANT: grant_o SHALL stay constant until ack_i=1, even if req_i of the granted requester drops.
REQ-020 GRANT with ack_i=1: SHALL return to IDLE, clear grant_q, and keep ptr and rem.
REQ-021 The minimum gap between grants SHALL be one IDLE cycle with grant_o=0.
REQ-022 ack_i in IDLE SHALL be ignored.
REQ-023 grant_o SHALL be zero or one-hot at all times.
REQ-024 grant_idx_o SHALL equal ptr.

Reset
REQ-025 On aresetn=0: state=IDLE, grant_o=0, busy_o=0, ptr=N_REQ-1, rem=0, grant_idx_o=N_REQ-1, regardless of any in-flight grant.
REQ-026 After reset, the first selection SHALL use the search path starting at index 0.

Structure
REQ-027 Package axi_xbar_pkg SHALL hold arb_state_t {IDLE, GRANT} and the eff_w weight-clamp function.
REQ-028 The rotating first-requester search SHALL be the combinational sub-module axi_rr_pick, with inputs req and ptr and outputs idx and found.
REQ-029 The block SHALL be a drop-in for the crossbar's per-slave write and read arbiters, using the same req/ack/grant semantics.

Verification
REQ-030 N_REQ=2, weights {3,1}, req_i=2'b11 held, ack_i one cycle after each grant -> grant_idx_o sequence 0,0,0,1,0,0,0,1.
REQ-031 Weights {0,0}, req_i=2'b11 held -> grants alternate 0,1,0,1 (zero treated as 1).
REQ-032 req_i=2'b10 only, weights {3,3} -> requester 1 granted on every arbitration; grant_o=2'b10 one cycle after req; 1 cycle low between grants.
REQ-033 Grant to requester 0, then req_i drops to 0 for 5 cycles with no ack_i -> grant_o stays 2'b01 and busy_o stays 1 until ack_i.
REQ-034 ack_i pulsed in IDLE with req_i=0 -> no state change; grant_o=0.
REQ-035 aresetn asserted mid-GRANT -> grant_o=0 and busy_o=0 immediately; with req_i=2'b11 after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/axi_xbar_pkg.sv
// rtl/axi_xbar_pkg.sv - shared arbiter types and weight helper
// Purpose: state type for the crossbar arbiters and the weight clamp that
//          turns a programmed weight of zero into a single grant.
// Ports:   none (package).
package axi_xbar_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // A weight of zero would starve the requester, so it counts as one grant.
    function automatic logic [31:0] eff_w(input logic [31:0] w);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// rtl/axi_rr_pick.sv - rotating first-requester search
// Purpose: finds the first set request bit in the order ptr+1, ptr+2, ...,
//          ptr+N_REQ (mod N_REQ).
// Ports:   req   - request vector, bit i = requester i
//          ptr   - index of the previous winner
//          idx   - index of the selected requester (0 when none)
//          found - high when any request bit is set
module axi_rr_pick #(
    parameter int N_REQ = 2,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] idx,
    output logic             found
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;

    always_comb begin
        // Duplicating the vector turns the modular wrap into a plain shift:
        // rot[k] corresponds to requester (ptr+1+k) mod N_REQ.
        dbl   = {req, req};
        rot   = N_REQ'(dbl >> (32'(ptr) + 32'd1));
        idx   = '0;
        found = 1'b0;
        // Scan downwards so the nearest requester after ptr is the last write.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = PTR_W'((32'(ptr) + 32'd1 + 32'(k)) % 32'(N_REQ));
            end
        end
    end

endmodule

// File: rtl/axi_wrr_arbiter.sv
// rtl/axi_wrr_arbiter.sv - weighted round-robin arbiter with held grant
// Purpose: grants one requester at a time; the previous winner may keep the
//          grant for up to its weight in consecutive arbitrations, after which
//          the search rotates on. A grant is held until ack_i.
// Ports:   aclk, aresetn - clock, asynchronous active-low reset
//          req_i         - per-requester request
//          weight_i      - packed weights, requester i at [i*WEIGHT_W +: WEIGHT_W]
//          ack_i         - releases the current grant
//          grant_o       - one-hot registered grant
//          grant_idx_o   - index of the last winner
//          busy_o        - high while a grant is held
module axi_wrr_arbiter
    import axi_xbar_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int WEIGHT_W = 4,
    localparam int PTR_W   = $clog2(N_REQ)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*WEIGHT_W-1:0] weight_i,
    input  logic                      ack_i,
    output logic [N_REQ-1:0]          grant_o,
    output logic [PTR_W-1:0]          grant_idx_o,
    output logic                      busy_o
);

    arb_state_t          state;
    logic [PTR_W-1:0]    ptr;
    logic [WEIGHT_W-1:0] rem;
    logic [N_REQ-1:0]    grant_q;

    logic [PTR_W-1:0]    pick_idx;
    logic                pick_found;
    logic [WEIGHT_W-1:0] pick_w;
    logic                favoured;
    logic [PTR_W-1:0]    win;
    logic [WEIGHT_W-1:0] rem_nxt;

    axi_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        pick_w   = weight_i[32'(pick_idx)*WEIGHT_W +: WEIGHT_W];
        // The last winner keeps priority while it still has grants left.
        favoured = req_i[ptr] && (rem != '0);
        if (favoured) begin
            win     = ptr;
            rem_nxt = rem - WEIGHT_W'(1);
        end else begin
            win     = pick_idx;
            rem_nxt = WEIGHT_W'(eff_w(32'(pick_w)) - 32'd1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            grant_q <= '0;
            // Starting at the last index makes the first search begin at 0.
            ptr     <= PTR_W'(N_REQ - 1);
            rem     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (favoured || pick_found) begin
                        state   <= GRANT;
                        grant_q <= N_REQ'(1) << win;
                        ptr     <= win;
                        rem     <= rem_nxt;
                    end
                end
                GRANT: begin
                    // ptr and rem persist so the next arbitration can favour
                    // the same requester.
                    if (ack_i) begin
                        state   <= IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = ptr;
    assign busy_o      = (state == GRANT);

endmodule

// File: tb/tb_axi_wrr_arbiter.sv
// tb/tb_axi_wrr_arbiter.sv - self-checking bench for axi_wrr_arbiter
module tb_axi_wrr_arbiter;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        aresetn;
    logic [1:0]  req2;
    logic [7:0]  wt2;
    logic        ack2;
    logic [1:0]  g2;
    logic [0:0]  idx2;
    logic        b2;
    logic [3:0]  req4;
    logic [15:0] wt4;
    logic        ack4;
    logic [3:0]  g4;
    logic [1:0]  idx4;
    logic        b4;

    axi_wrr_arbiter #(.N_REQ(2), .WEIGHT_W(4)) u_dut (
        .aclk(aclk), .aresetn(aresetn), .req_i(req2), .weight_i(wt2),
        .ack_i(ack2), .grant_o(g2), .grant_idx_o(idx2), .busy_o(b2)
    );

    axi_wrr_arbiter #(.N_REQ(4), .WEIGHT_W(4)) u_dut4 (
        .aclk(aclk), .aresetn(aresetn), .req_i(req4), .weight_i(wt4),
        .ack_i(ack4), .grant_o(g4), .grant_idx_o(idx4), .busy_o(b4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0] req;
        logic [7:0] wt;
        logic       ack;
        logic [1:0] g;
        logic       b;
        logic       idx;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic [1:0] req, input logic [7:0] wt, input logic ack,
                                input logic [1:0] g, input logic b, input logic idx);
        vec_t v;
        v.req = req; v.wt = wt; v.ack = ack; v.g = g; v.b = b; v.idx = idx;
        tbl.push_back(v);
    endfunction

    // Reference model: tracks who won last, how many consecutive grants that
    // winner has had in its current streak, and the quota fixed when the
    // streak began.
    int nr[2] = '{2, 4};
    int m_last[2], m_streak[2], m_quota[2];
    bit m_busy[2];

    function automatic void model_reset(input int i);
        m_last[i] = nr[i] - 1; m_streak[i] = 0; m_quota[i] = 0; m_busy[i] = 0;
    endfunction

    function automatic void model_edge(input int i, input logic [3:0] req,
                                       input logic [15:0] wt, input logic ack);
        int w, wv;
        if (!m_busy[i]) begin
            if (req != 4'd0) begin
                if (req[m_last[i]] && m_streak[i] < m_quota[i]) begin
                    m_streak[i]++;
                end else begin
                    w = -1;
                    for (int k = 1; k <= nr[i]; k++)
                        if (w < 0 && req[(m_last[i] + k) % nr[i]]) w = (m_last[i] + k) % nr[i];
                    wv = int'((wt >> (4 * w)) & 16'hF);
                    m_last[i]   = w;
                    m_quota[i]  = (wv == 0) ? 1 : wv;
                    m_streak[i] = 1;
                end
                m_busy[i] = 1;
            end
        end else if (ack) begin
            m_busy[i] = 0;
        end
    endfunction

    initial begin
        aresetn = 1'b0;
        req2 = '0; wt2 = '0; ack2 = 1'b0;
        req4 = '0; wt4 = '0; ack4 = 1'b0;

        // Weights {w0=3,w1=1}: 0,0,0,1,0,0,0,1 with ack one cycle after each grant
        for (int r = 0; r < 2; r++) begin
            for (int n = 0; n < 3; n++) begin
                add(2'b11, 8'h13, 1'b0, 2'b01, 1'b1, 1'b0);
                add(2'b11, 8'h13, 1'b1, 2'b00, 1'b0, 1'b0);
            end
            add(2'b11, 8'h13, 1'b0, 2'b10, 1'b1, 1'b1);
            add(2'b11, 8'h13, 1'b1, 2'b00, 1'b0, 1'b1);
        end
        // Zero weights alternate
        for (int n = 0; n < 2; n++) begin
            add(2'b11, 8'h00, 1'b0, 2'b01, 1'b1, 1'b0);
            add(2'b11, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0);
            add(2'b11, 8'h00, 1'b0, 2'b10, 1'b1, 1'b1);
            add(2'b11, 8'h00, 1'b1, 2'b00, 1'b0, 1'b1);
        end
        // Only requester 1: granted every arbitration, one idle cycle between
        for (int n = 0; n < 3; n++) begin
            add(2'b10, 8'h33, 1'b0, 2'b10, 1'b1, 1'b1);
            add(2'b10, 8'h33, 1'b1, 2'b00, 1'b0, 1'b1);
        end
        // ack in IDLE with no request is ignored
        add(2'b00, 8'h33, 1'b1, 2'b00, 1'b0, 1'b1);
        add(2'b00, 8'h33, 1'b1, 2'b00, 1'b0, 1'b1);
        // Grant held while request drops, until ack
        add(2'b01, 8'h33, 1'b0, 2'b01, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) add(2'b00, 8'h33, 1'b0, 2'b01, 1'b1, 1'b0);
        add(2'b00, 8'h33, 1'b1, 2'b00, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(negedge aclk);
        chk("rst_grant2", 32'(g2), 32'd0);
        chk("rst_busy2", 32'(b2), 32'd0);
        chk("rst_idx2", 32'(idx2), 32'd1);
        chk("rst_grant4", 32'(g4), 32'd0);
        chk("rst_idx4", 32'(idx4), 32'd3);
        aresetn = 1'b1;

        foreach (tbl[i]) begin
            req2 = tbl[i].req; wt2 = tbl[i].wt; ack2 = tbl[i].ack;
            @(posedge aclk);
            @(negedge aclk);
            chk($sformatf("vec%0d_grant", i), 32'(g2), 32'(tbl[i].g));
            chk($sformatf("vec%0d_busy", i), 32'(b2), 32'(tbl[i].b));
            chk($sformatf("vec%0d_idx", i), 32'(idx2), 32'(tbl[i].idx));
        end

        // Reset asserted mid-grant clears outputs immediately
        req2 = 2'b11; wt2 = 8'h11; ack2 = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("pre_rst_busy", 32'(b2), 32'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(g2), 32'd0);
        chk("mid_rst_busy", 32'(b2), 32'd0);
        chk("mid_rst_idx", 32'(idx2), 32'd1);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("post_rst_grant", 32'(g2), 32'd1);
        chk("post_rst_idx", 32'(idx2), 32'd0);

        // Randomized run against the reference model, both sizes
        aresetn = 1'b0;
        req2 = '0; ack2 = 1'b0; req4 = '0; ack4 = 1'b0;
        model_reset(0);
        model_reset(1);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req2 = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'($urandom);
            wt2  = 8'($urandom);
            ack2 = ($urandom_range(0, 2) == 0);
            req4 = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
            wt4  = 16'($urandom);
            ack4 = ($urandom_range(0, 2) == 0);
            @(posedge aclk);
            model_edge(0, {2'b00, req2}, {8'h00, wt2}, ack2);
            model_edge(1, req4, wt4, ack4);
            @(negedge aclk);
            chk("rnd2_grant", 32'(g2), m_busy[0] ? (32'd1 << m_last[0]) : 32'd0);
            chk("rnd2_busy", 32'(b2), 32'(m_busy[0]));
            chk("rnd2_idx", 32'(idx2), 32'(m_last[0]));
            chk("rnd4_grant", 32'(g4), m_busy[1] ? (32'd1 << m_last[1]) : 32'd0);
            chk("rnd4_busy", 32'(b4), 32'(m_busy[1]));
            chk("rnd4_idx", 32'(idx4), 32'(m_last[1]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
